// File: rtl/label_pkg.sv
// Shared definitions for the label demultiplexer and its transmit-side labeler.
package label_pkg;

    typedef enum logic [1:0] {
        HEADER = 2'd0,
        ROUTE  = 2'd1,
        DROP   = 2'd2
    } state_e;

    localparam int DROP_CNT_W  = 16;
    localparam int LABEL_W     = 8;
    localparam int LABEL_BEATS = 1;

endpackage

// File: rtl/label_demux_out_reg.sv
// Single-entry output register with a destination field and one-hot valid decode.
module label_demux_out_reg #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_OUTPUTS = 4,
    parameter int SEL_W       = $clog2(NUM_OUTPUTS)
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   load,
    input  logic [DATA_WIDTH-1:0]  load_data,
    input  logic                   load_last,
    input  logic [SEL_W-1:0]       load_dest,
    input  logic [NUM_OUTPUTS-1:0] out_tready,
    output logic [NUM_OUTPUTS-1:0] out_tvalid,
    output logic [DATA_WIDTH-1:0]  out_tdata,
    output logic                   out_tlast,
    output logic                   can_load
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic [SEL_W-1:0]      dest_q, dest_d;
    logic                  drain;

    for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_decode
        assign out_tvalid[gi] = valid_q && (dest_q == SEL_W'(gi));
    end

    // Only the addressed consumer's ready matters; others are masked by the decode.
    assign drain     = |(out_tvalid & out_tready);
    assign can_load  = !valid_q || drain;
    assign out_tdata = data_q;
    assign out_tlast = last_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        dest_d  = dest_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            last_d  = load_last;
            dest_d  = load_dest;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            dest_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            dest_q  <= dest_d;
        end
    end

endmodule

// File: rtl/label_demux.sv
// Strips the leading label beat of each packet and steers the payload to one of NUM_OUTPUTS streams.
module label_demux
    import label_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_OUTPUTS = 4
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   in_tvalid,
    output logic                   in_tready,
    input  logic [DATA_WIDTH-1:0]  in_tdata,
    input  logic                   in_tlast,
    output logic [NUM_OUTPUTS-1:0] out_tvalid,
    input  logic [NUM_OUTPUTS-1:0] out_tready,
    output logic [DATA_WIDTH-1:0]  out_tdata,
    output logic                   out_tlast,
    output logic [DROP_CNT_W-1:0]  drop_count,
    output logic                   drop_pulse
);

    localparam int SEL_W = $clog2(NUM_OUTPUTS);
    localparam logic [DATA_WIDTH-1:0] NUM_OUT_L = DATA_WIDTH'(NUM_OUTPUTS);

    state_e                state_q, state_d;
    logic [SEL_W-1:0]      route_sel_q, route_sel_d;
    logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;
    logic                  drop_pulse_q, drop_pulse_d;

    logic accept;
    logic label_ok;
    logic drop_event;
    logic load;
    logic can_load;

    // Full-width compare so a label like 0x84 is not aliased onto output 0.
    assign label_ok   = in_tdata < NUM_OUT_L;
    assign accept     = in_tvalid && in_tready;
    assign drop_event = accept && (state_q == HEADER) && (in_tlast || !label_ok);
    assign load       = accept && (state_q == ROUTE);

    always_comb begin
        state_d      = state_q;
        route_sel_d  = route_sel_q;
        drop_count_d = drop_count_q;
        drop_pulse_d = drop_event;
        in_tready    = 1'b1;

        case (state_q)
            HEADER: begin
                if (accept && !in_tlast) begin
                    if (label_ok) begin
                        route_sel_d = in_tdata[SEL_W-1:0];
                        state_d     = ROUTE;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            ROUTE: begin
                in_tready = can_load;
                if (accept && in_tlast) begin
                    state_d = HEADER;
                end
            end
            DROP: begin
                if (accept && in_tlast) begin
                    state_d = HEADER;
                end
            end
            default: begin
                state_d = HEADER;
            end
        endcase

        if (drop_event && !(&drop_count_q)) begin
            drop_count_d = drop_count_q + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= HEADER;
            route_sel_q  <= '0;
            drop_count_q <= '0;
            drop_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            route_sel_q  <= route_sel_d;
            drop_count_q <= drop_count_d;
            drop_pulse_q <= drop_pulse_d;
        end
    end

    assign drop_count = drop_count_q;
    assign drop_pulse = drop_pulse_q;

    label_demux_out_reg #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_OUTPUTS (NUM_OUTPUTS),
        .SEL_W       (SEL_W)
    ) u_out_reg (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .load       (load),
        .load_data  (in_tdata),
        .load_last  (in_tlast),
        .load_dest  (route_sel_q),
        .out_tready (out_tready),
        .out_tvalid (out_tvalid),
        .out_tdata  (out_tdata),
        .out_tlast  (out_tlast),
        .can_load   (can_load)
    );

endmodule

// File: tb/tb_label_demux.sv
// Directed scoreboard bench for label_demux: stimulus pushes expected beats, a monitor pops on each output handshake.
module tb_label_demux;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        in_tvalid;
    logic        in_tready;
    logic [7:0]  in_tdata;
    logic        in_tlast;
    logic [3:0]  out_tvalid;
    logic [3:0]  out_tready;
    logic [7:0]  out_tdata;
    logic        out_tlast;
    logic [15:0] drop_count;
    logic        drop_pulse;

    typedef struct {
        int         port;
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 aclk = ~aclk;

    label_demux #(.DATA_WIDTH(8), .NUM_OUTPUTS(4)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .in_tdata   (in_tdata),
        .in_tlast   (in_tlast),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tdata  (out_tdata),
        .out_tlast  (out_tlast),
        .drop_count (drop_count),
        .drop_pulse (drop_pulse)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
            $display("ok   %s act=%0h exp=%0h", name, act, exp);
        end else begin
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic expect_beat(input int port, input logic [7:0] data, input logic last);
        exp_t e;
        e.port = port;
        e.data = data;
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Drives one beat and returns after the edge on which it was accepted.
    task automatic send_beat(input logic [7:0] data, input logic last, output int waits);
        bit done;
        done      = 0;
        waits     = 0;
        in_tvalid = 1'b1;
        in_tdata  = data;
        in_tlast  = last;
        while (!done && waits < 50) begin
            @(negedge aclk);
            if (in_tready) done = 1;
            @(posedge aclk);
            #1;
            if (!done) waits++;
        end
        in_tvalid = 1'b0;
        if (!done) chk("send_timeout", 32'(data), 32'hFFFF_FFFF);
    endtask

    // Monitor: every output handshake must match the head of the scoreboard.
    always @(negedge aclk) begin
        if (aresetn === 1'b1 && |(out_tvalid & out_tready)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {24'd0, out_tdata}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_tvalid", 32'(out_tvalid), 32'(4'b0001 << e.port));
                chk("mon_tdata", 32'(out_tdata), 32'(e.data));
                chk("mon_tlast", 32'(out_tlast), 32'(e.last));
            end
        end
    end

    initial begin
        int w;
        aresetn    = 1'b0;
        in_tvalid  = 1'b0;
        in_tdata   = '0;
        in_tlast   = 1'b0;
        out_tready = 4'b1111;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;

        // Reset state
        @(negedge aclk);
        chk("rst_tvalid", 32'(out_tvalid), 32'h0);
        chk("rst_tdata", 32'(out_tdata), 32'h0);
        chk("rst_tlast", 32'(out_tlast), 32'h0);
        chk("rst_drop_count", 32'(drop_count), 32'h0);
        chk("rst_drop_pulse", 32'(drop_pulse), 32'h0);
        chk("rst_in_tready", 32'(in_tready), 32'h1);
        @(posedge aclk); #1;

        // Packet to output 2, all ready: beats stream without input stalls
        expect_beat(2, 8'hA1, 1'b0);
        expect_beat(2, 8'hA2, 1'b0);
        expect_beat(2, 8'hA3, 1'b1);
        send_beat(8'h02, 1'b0, w); chk("p1_hdr_wait", 32'(w), 0);
        send_beat(8'hA1, 1'b0, w); chk("p1_b1_wait", 32'(w), 0);
        send_beat(8'hA2, 1'b0, w); chk("p1_b2_wait", 32'(w), 0);
        send_beat(8'hA3, 1'b1, w); chk("p1_b3_wait", 32'(w), 0);
        @(negedge aclk);
        chk("p1_drop_count", 32'(drop_count), 0);
        @(posedge aclk); #1;

        // Out-of-range label 7: consumed with in_tready high, one drop pulse
        send_beat(8'h07, 1'b0, w); chk("p2_hdr_wait", 32'(w), 0);
        chk("p2_drop_pulse_hi", 32'(drop_pulse), 1);
        send_beat(8'h11, 1'b0, w); chk("p2_b1_wait", 32'(w), 0);
        chk("p2_drop_pulse_lo", 32'(drop_pulse), 0);
        send_beat(8'h22, 1'b1, w); chk("p2_b2_wait", 32'(w), 0);
        chk("p2_tvalid_idle", 32'(out_tvalid), 0);
        chk("p2_drop_count", 32'(drop_count), 1);

        // Label-only packet dropped, then a real packet to output 1
        send_beat(8'h01, 1'b1, w);
        chk("p3_drop_pulse", 32'(drop_pulse), 1);
        chk("p3_drop_count", 32'(drop_count), 2);
        expect_beat(1, 8'h55, 1'b1);
        send_beat(8'h01, 1'b0, w);
        send_beat(8'h55, 1'b1, w);
        @(negedge aclk);
        chk("p3b_drop_count", 32'(drop_count), 2);
        @(posedge aclk); #1;

        // Label 3 (highest valid) with a 5-cycle stall on output 3
        expect_beat(3, 8'h31, 1'b0);
        expect_beat(3, 8'h32, 1'b0);
        expect_beat(3, 8'h33, 1'b0);
        expect_beat(3, 8'h34, 1'b1);
        send_beat(8'h03, 1'b0, w);
        send_beat(8'h31, 1'b0, w);
        out_tready = 4'b0111;
        in_tvalid  = 1'b1;
        in_tdata   = 8'h32;
        in_tlast   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("stall_in_tready", 32'(in_tready), 0);
            chk("stall_tdata", 32'(out_tdata), 32'h31);
            chk("stall_tvalid", 32'(out_tvalid), 32'h8);
            @(posedge aclk); #1;
            out_tready[0] = ~out_tready[0];
        end
        out_tready = 4'b1111;
        send_beat(8'h32, 1'b0, w);
        send_beat(8'h33, 1'b0, w);
        send_beat(8'h34, 1'b1, w);
        repeat (2) @(posedge aclk); #1;

        // Back-to-back packets to 0 then 1, output 0 slow on its last beat
        expect_beat(0, 8'h41, 1'b0);
        expect_beat(0, 8'h42, 1'b1);
        expect_beat(1, 8'h51, 1'b0);
        expect_beat(1, 8'h52, 1'b1);
        send_beat(8'h00, 1'b0, w);
        send_beat(8'h41, 1'b0, w);
        send_beat(8'h42, 1'b1, w);
        out_tready[0] = 1'b0;
        send_beat(8'h01, 1'b0, w); chk("p5_hdr_not_stalled", 32'(w), 0);
        fork
            begin
                repeat (3) @(posedge aclk);
                #1 out_tready[0] = 1'b1;
            end
            begin
                send_beat(8'h51, 1'b0, w);
                chk("p5_b1_waited", 32'(w >= 2), 1);
                send_beat(8'h52, 1'b1, w);
            end
        join
        repeat (2) @(posedge aclk); #1;

        // Reset mid-packet on output 2: held beat lost, next beat is a label
        out_tready = 4'b0000;
        send_beat(8'h02, 1'b0, w);
        send_beat(8'h61, 1'b0, w);
        @(negedge aclk);
        chk("p6_held_tvalid", 32'(out_tvalid), 32'h4);
        @(posedge aclk); #1;
        aresetn = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        chk("p6_rst_tvalid", 32'(out_tvalid), 0);
        chk("p6_rst_drop_count", 32'(drop_count), 0);
        out_tready = 4'b1111;
        expect_beat(0, 8'h71, 1'b1);
        send_beat(8'h00, 1'b0, w);
        send_beat(8'h71, 1'b1, w);

        // Label 4 and 0x84 both dropped (no truncation onto output 0)
        send_beat(8'h04, 1'b0, w);
        send_beat(8'h81, 1'b1, w);
        chk("p7_drop_count_4", 32'(drop_count), 1);
        send_beat(8'h84, 1'b0, w);
        send_beat(8'h82, 1'b1, w);
        chk("p7_drop_count_84", 32'(drop_count), 2);

        repeat (4) @(posedge aclk); #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
